dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the core load/store path and a host burst engine used for preload and dump of memory images.
- The core is single-cycle and cannot stall, so it always has priority. The host moves one byte per free cycle, with valid/ready streams in each direction.
- Sits between the core's memory signals and dat_mem. It drives the memory address, write enable and write data.

Parameters:
- AW, 8, memory address width (addresses wrap mod 2^AW)
- DW, 8, data width
- CW, 16, width of the deferred-cycle statistics counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_load  in  1  core reads memory this cycle
- cpu_store  in  1  core writes memory this cycle
- cpu_addr  in  AW  core address
- cpu_wdat  in  DW  core store data
- cpu_rdat  out  DW  read data to the core (combinational = mem_rdat)
- mem_addr  out  AW  address to dat_mem
- mem_wr_en  out  1  write enable to dat_mem
- mem_wdat  out  DW  write data to dat_mem
- mem_rdat  in  DW  dat_mem combinational read data
- host_start  in  1  start a burst (sampled only in IDLE)
- host_dir  in  1  0 = host writes memory, 1 = host reads memory
- host_base  in  AW  burst start address
- host_len  in  AW+1  burst length in bytes; 0 is legal
- host_abort  in  1  cancel the burst
- host_busy  out  1  burst in progress (state != IDLE)
- host_done  out  1  one-cycle pulse on burst completion
- wr_valid  in  1  host write byte valid
- wr_data  in  DW  host write byte
- wr_ready  out  1  write byte accepted when wr_valid && wr_ready
- rd_valid  out  1  host read byte available
- rd_data  out  DW  host read byte
- rd_ready  in  1  host consumes the read byte
- defer_cnt  out  CW  saturating count of cycles the host was blocked by the core

Behaviour:
- Reset (async, any state): state = IDLE; addr, remaining and defer_cnt = 0; rd_valid = 0; rd_data = 0; host_done = 0. Reset mid-burst discards the burst; no done pulse.
- cpu_act = cpu_load | cpu_store.
  - When cpu_act = 1: mem_addr = cpu_addr, mem_wdat = cpu_wdat, mem_wr_en = cpu_store.
  - When cpu_act = 0: the host owns the port, with mem_addr = addr and mem_wdat = wr_data.
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE: on host_start, latch addr = host_base and remaining = host_len.
  - If host_len == 0, go to DONE.
  - Otherwise go to WRITE or READ according to host_dir.
  - host_start in any other state is ignored.
- WRITE:
  - wr_ready = !cpu_act, combinational.
  - On fire: mem_wr_en = 1, addr += 1 (wraps), remaining -= 1.
  - If remaining was 1, go to DONE.
- READ:
  - slot = !cpu_act && remaining != 0 && (!rd_valid || rd_ready).
  - On slot: rd_data <= mem_rdat at addr, rd_valid <= 1, addr += 1, remaining -= 1. mem_wr_en stays 0.
  - If rd_valid && rd_ready && no slot, rd_valid <= 0.
  - Go to DONE when remaining == 0 and the last byte is consumed (rd_valid && rd_ready with no slot).
  - rd_data is stable while rd_valid && !rd_ready.
- DONE: host_done = 1 for exactly one cycle, then IDLE. host_busy = 1 in DONE.
- host_abort (WRITE or READ): next state IDLE, rd_valid <= 0, no host_done. Abort has priority over a same-cycle fire; that byte is not written.
- defer_cnt increments when state is WRITE with wr_valid && cpu_act, or state is READ with remaining != 0 && cpu_act. It saturates at 2^CW-1 and is cleared only by reset.
- A core write and a host write never reach memory in the same cycle; the core always wins.
- Latency:
  - Host write: the byte is in memory at the clock edge on which it fires.
  - Host read: rd_valid rises 1 cycle after the first free slot.
- Throughput: 1 byte/cycle with no core activity and a ready consumer.

Test Plan:
- Write burst, no core traffic: host_start, dir=0, base=0x10, len=4, bytes AA,BB,CC,DD back-to-back -> mem[0x10..0x13]=AA,BB,CC,DD; host_done pulses once, 1 cycle after the 4th fire; defer_cnt=0.
- Core conflict: write burst len=3 with cpu_store to 0x50 (data 0x77) on the 2nd cycle -> wr_ready=0 that cycle; mem[0x50]=0x77; host bytes land at consecutive addresses; defer_cnt=1.
- Read burst with backpressure: preload mem[0xFE]=1, mem[0xFF]=2, mem[0x00]=3; dir=1, base=0xFE, len=3; rd_ready low for 2 cycles after the first rd_valid -> output 1,2,3 in order; rd_data held during stall; address wraps 0xFF->0x00; single done pulse.
- Zero length: host_start with len=0 -> DONE the next cycle, host_done pulse, no memory write, no rd_valid.
- Abort and reset: abort a write burst after 2 of 5 bytes -> only 2 bytes written, no host_done, IDLE next cycle. Assert reset mid-read -> rd_valid=0 and host_busy=0 immediately (async).
- Ignore start: host_start pulsed while busy -> no effect on addr/len; the current burst completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the single-cycle core always owns the port when active,
// and a host burst engine moves one byte per free cycle over valid/ready streams.
module dmem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_load,
    input  logic          cpu_store,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdat,
    output logic [DW-1:0] cpu_rdat,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_wdat,
    input  logic [DW-1:0] mem_rdat,
    input  logic          host_start,
    input  logic          host_dir,
    input  logic [AW-1:0] host_base,
    input  logic [AW:0]   host_len,
    input  logic          host_abort,
    output logic          host_busy,
    output logic          host_done,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          rd_ready,
    output logic [CW-1:0] defer_cnt,
    output logic [1:0]    dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   rem_q, rem_d;
    logic [CW-1:0] defer_q, defer_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic cpu_act, in_burst, rem_zero, wr_fire, rd_slot, rd_take, blocked;

    // Handshakes: a write byte transfers when wr_valid && wr_ready; a read byte
    // transfers when rd_valid && rd_ready. rd_data holds while rd_valid && !rd_ready.
    assign cpu_act  = cpu_load | cpu_store;
    assign in_burst = (state_q == S_WRITE) || (state_q == S_READ);
    assign rem_zero = (rem_q == '0);
    assign wr_fire  = (state_q == S_WRITE) && wr_valid && !cpu_act && !host_abort;
    assign rd_slot  = (state_q == S_READ) && !cpu_act && !rem_zero && (!rd_valid_q || rd_ready);
    assign rd_take  = rd_valid_q && rd_ready;
    assign blocked  = cpu_act && (((state_q == S_WRITE) && wr_valid) ||
                                  ((state_q == S_READ) && !rem_zero));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            defer_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            defer_q    <= defer_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (host_start) begin
                    if (host_len == '0)
                        state_d = S_DONE;
                    else if (host_dir)
                        state_d = S_READ;
                    else
                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (host_abort)
                    state_d = S_IDLE;
                else if (wr_fire && (rem_q == (AW+1)'(1)))
                    state_d = S_DONE;
            end
            S_READ: begin
                if (host_abort)
                    state_d = S_IDLE;
                else if (rem_zero && rd_take)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Burst datapath: address/remaining bookkeeping, read holding register, stats.
    always_comb begin
        addr_d     = addr_q;
        rem_d      = rem_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        defer_d    = (blocked && (defer_q != '1)) ? defer_q + CW'(1) : defer_q;
        if ((state_q == S_IDLE) && host_start) begin
            addr_d = host_base;
            rem_d  = host_len;
        end else if (in_burst && host_abort) begin
            rd_valid_d = 1'b0;
        end else begin
            if (wr_fire || rd_slot) begin
                addr_d = addr_q + AW'(1);
                rem_d  = rem_q - (AW+1)'(1);
            end
            if (rd_slot) begin
                rd_valid_d = 1'b1;
                rd_data_d  = mem_rdat;
            end else if (rd_take) begin
                rd_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        mem_addr  = addr_q;
        mem_wdat  = wr_data;
        mem_wr_en = wr_fire;
        if (cpu_act) begin
            mem_addr  = cpu_addr;
            mem_wdat  = cpu_wdat;
            mem_wr_en = cpu_store;
        end
        wr_ready  = (state_q == S_WRITE) && !cpu_act;
        host_busy = (state_q != S_IDLE);
        host_done = (state_q == S_DONE);
    end

    assign cpu_rdat  = mem_rdat;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign defer_cnt = defer_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory model, directed scenarios and randomized
// bursts scored against a reference image of memory and expected read queues.
module tb_dmem_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_load, cpu_store;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdat, cpu_rdat;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wdat, mem_rdat;
    logic          host_start, host_dir, host_abort, host_busy, host_done;
    logic [AW-1:0] host_base;
    logic [AW:0]   host_len;
    logic          wr_valid, wr_ready, rd_valid, rd_ready;
    logic [DW-1:0] wr_data, rd_data;
    logic [CW-1:0] defer_cnt;
    logic [1:0]    dbg_state;

    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] wq[$];
    logic [DW-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int exp_defer = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .cpu_load(cpu_load), .cpu_store(cpu_store), .cpu_addr(cpu_addr),
        .cpu_wdat(cpu_wdat), .cpu_rdat(cpu_rdat),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdat(mem_wdat), .mem_rdat(mem_rdat),
        .host_start(host_start), .host_dir(host_dir), .host_base(host_base),
        .host_len(host_len), .host_abort(host_abort), .host_busy(host_busy),
        .host_done(host_done),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .defer_cnt(defer_cnt), .dbg_state(dbg_state)
    );

    // Clock and memory model (combinational read, write on the rising edge).
    always #5 clk = ~clk;
    assign mem_rdat = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr_en)
            mem[mem_addr] <= mem_wdat;
        else if (pl_en)
            mem[pl_addr] <= pl_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_load = 0; cpu_store = 0; cpu_addr = '0; cpu_wdat = '0;
        host_start = 0; host_dir = 0; host_base = '0; host_len = '0; host_abort = 0;
        wr_valid = 0; wr_data = '0; rd_ready = 0; pl_en = 0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pl_en = 0;
    endtask

    task automatic check_mem(input string tag);
        int nbad = 0;
        for (int a = 0; a < 256; a++)
            if (mem[a] !== ref_mem[a]) nbad++;
        chk(tag, nbad, 0);
    endtask

    task automatic check_done(input string tag);
        idle_inputs();
        #1;
        chk({tag, "_done"}, host_done, 1);
        chk({tag, "_busy_in_done"}, host_busy, 1);
        @(negedge clk);
        #1;
        chk({tag, "_done_clear"}, host_done, 0);
        chk({tag, "_idle"}, host_busy, 0);
        chk({tag, "_defer"}, defer_cnt, exp_defer[CW-1:0]);
    endtask

    task automatic start_burst(input logic dir, input logic [7:0] base, input int len);
        @(negedge clk);
        host_start = 1; host_dir = dir; host_base = base; host_len = 9'(len);
        @(negedge clk);
        host_start = 0;
    endtask

    // Host write burst of wq[0..len-1]; hit_cyc forces a core store of 0x77 to 0x50.
    task automatic write_burst(input logic [7:0] base, input int len, input int cpu_pct,
                               input int vpct, input int hit_cyc, input bit glitch);
        int sent = 0;
        int cyc = 0;
        bit act;
        start_burst(1'b0, base, len);
        while (sent < len && cyc < 200) begin
            cpu_load = 0; cpu_store = 0;
            if (cyc == hit_cyc) begin
                cpu_store = 1; cpu_addr = 8'h50; cpu_wdat = 8'h77;
            end else if ($urandom_range(99) < cpu_pct) begin
                if ($urandom_range(1) == 1) cpu_store = 1; else cpu_load = 1;
                cpu_addr = 8'($urandom); cpu_wdat = 8'($urandom);
            end
            host_start = glitch && (cyc == 1);
            host_dir = glitch; host_base = 8'hA0; host_len = 9'd7;
            wr_valid = ($urandom_range(99) < vpct);
            wr_data = wq[sent];
            act = cpu_load | cpu_store;
            #1;
            chk("wr_ready", wr_ready, !act);
            if (cpu_load) chk("cpu_rdat_w", cpu_rdat, ref_mem[cpu_addr]);
            if (cpu_store) ref_mem[cpu_addr] = cpu_wdat;
            if (wr_valid && act) exp_defer++;
            if (wr_valid && !act) begin
                ref_mem[8'(base + sent)] = wr_data;
                sent++;
            end
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 200) chk("wr_timeout", 0, 1);
        check_done("wr");
        check_mem("wr_mem");
    endtask

    // Host read burst; the model tracks the single output register and issued count.
    task automatic read_burst(input logic [7:0] base, input int len, input int cpu_pct,
                              input int ready_pct, input bit stall_first);
        int got = 0;
        int issued = 0;
        int cyc = 0;
        int stall = 0;
        bit mval = 0;
        bit seen = 0;
        bit hold = 0;
        bit slot;
        logic [7:0] held = '0;
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[8'(base + i)]);
        start_burst(1'b1, base, len);
        while (got < len && cyc < 300) begin
            cpu_store = 0;
            cpu_load = ($urandom_range(99) < cpu_pct);
            cpu_addr = 8'($urandom);
            if (stall_first && mval && !seen) begin seen = 1; stall = 2; end
            rd_ready = (stall > 0) ? 1'b0 : ($urandom_range(99) < ready_pct);
            if (stall > 0) stall--;
            #1;
            chk("rd_valid", rd_valid, mval);
            if (hold) chk("rd_hold", rd_data, held);
            if (cpu_load) chk("cpu_rdat_r", cpu_rdat, ref_mem[cpu_addr]);
            if (cpu_load && issued < len) exp_defer++;
            slot = !cpu_load && (issued < len) && (!mval || rd_ready);
            if (mval && rd_ready) begin
                chk("rd_data", rd_data, exp_q.pop_front());
                got++;
            end
            hold = mval && !rd_ready;
            held = rd_data;
            if (slot) begin
                mval = 1; issued++;
            end else if (mval && rd_ready) begin
                mval = 0;
            end
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 300) chk("rd_timeout", 0, 1);
        check_done("rd");
        chk("rd_valid_after", rd_valid, 0);
    endtask

    initial begin
        int len;
        logic [7:0] base;
        idle_inputs();
        pl_addr = '0; pl_data = '0;
        reset = 1;
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            pl_en = 1; pl_addr = 8'(a); pl_data = 8'($urandom);
            ref_mem[a] = pl_data;
        end
        @(negedge clk);
        pl_en = 0;
        #1;
        chk("rst_busy", host_busy, 0);
        chk("rst_done", host_done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_defer", defer_cnt, 0);
        chk("rst_wr_ready", wr_ready, 0);
        reset = 0;
        check_mem("preload_mem");

        // Back-to-back write, then a core store colliding on the 2nd cycle.
        wq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        write_burst(8'h10, 4, 0, 100, -1, 1'b0);
        chk("wr_mem_10", mem[8'h10], 8'hAA);
        chk("wr_mem_13", mem[8'h13], 8'hDD);
        wq = '{8'h11, 8'h22, 8'h33};
        write_burst(8'h60, 3, 0, 100, 1, 1'b0);
        chk("conflict_mem_50", mem[8'h50], 8'h77);
        chk("conflict_mem_62", mem[8'h62], 8'h33);
        chk("conflict_defer", defer_cnt, 1);

        // A start pulse mid-burst must not disturb the running write.
        wq = '{8'h5A, 8'hA5, 8'h3C};
        write_burst(8'hC0, 3, 0, 100, -1, 1'b1);

        // Zero-length burst.
        start_burst(1'b0, 8'h33, 0);
        #1;
        chk("zero_rd_valid", rd_valid, 0);
        check_done("zero");
        check_mem("zero_mem");

        // Wrapping read with two stall cycles after the first byte appears.
        preload(8'hFE, 8'h01);
        preload(8'hFF, 8'h02);
        preload(8'h00, 8'h03);
        read_burst(8'hFE, 3, 0, 100, 1'b1);

        // Abort after two of five bytes; the third (same-cycle) byte is dropped.
        start_burst(1'b0, 8'h80, 5);
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1; wr_data = 8'hE0 + 8'(i);
            host_abort = (i == 2);
            if (i < 2) ref_mem[8'h80 + 8'(i)] = wr_data;
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk("abort_idle", host_busy, 0);
        chk("abort_no_done", host_done, 0);
        @(negedge clk);
        #1;
        chk("abort_no_done_late", host_done, 0);
        check_mem("abort_mem");

        // Randomized write/read bursts with core traffic and consumer backpressure.
        for (int n = 0; n < 8; n++) begin
            base = 8'($urandom);
            len = $urandom_range(12, 1);
            wq.delete();
            for (int i = 0; i < len; i++) wq.push_back(8'($urandom));
            write_burst(base, len, 30, 70, -1, 1'b0);
            read_burst(8'($urandom), $urandom_range(12, 1), 30, 60, 1'b0);
        end
        read_burst(base, len, 0, 100, 1'b0);

        // Asynchronous reset in the middle of a read.
        start_burst(1'b1, 8'h20, 4);
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_rd_valid", rd_valid, 1);
        #1 reset = 1;
        #1;
        chk("async_rst_rd_valid", rd_valid, 0);
        chk("async_rst_busy", host_busy, 0);
        chk("async_rst_defer", defer_cnt, 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        #1;
        chk("post_rst_done", host_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
